projective_transform: RTL and testbench
=======================================

Name: projective_transform

Overview:
- Streams one 640x480 source frame in raster order.
- For each source pixel, computes its destination coordinate inside a quadrilateral given by four corners: A maps to source top-left, B to top-right, C to bottom-right, D to bottom-left.
- The mapping is bilinear. Each pixel is emitted with its destination coordinate as a write request to the frame-buffer writer.
- Sits between the camera/frame-buffer reader and the display frame-buffer writer.

Parameters:
- WIDTH, 640, source columns per row.
- HEIGHT, 480, source rows per frame.
- FRAC, 20, fractional bits of the internal fixed-point accumulators.

Ports:
- clk in 1: system clock; all logic on rising edge.
- reset_n in 1: synchronous, active-low reset.
- frame_flag in 1: start-of-frame request; sampled only in IDLE.
- pixel in 18: source pixel data.
- pixel_flag in 1: pixel valid, answering an outstanding request_pixel.
- a_x in 10, a_y in 9: corner A.
- b_x in 10, b_y in 9: corner B.
- c_x in 10, c_y in 9: corner C.
- d_x in 10, d_y in 9: corner D.
- ptflag in 1: 1 = transform enabled; 0 = identity mapping.
- pt_pixel_write out 18: pixel to write.
- pt_x out 10, pt_y out 9: destination coordinate.
- pt_wr out 1: one-cycle write strobe.
- request_pixel out 1: one-cycle pulse requesting the next source pixel.

Behaviour:
- Reset (reset_n=0 at clk edge): state IDLE; all outputs 0; row/column counters 0; no request outstanding.
- IDLE:
  - On frame_flag=1, latch all eight corner inputs and ptflag, clear x and y, go to ROW_SETUP.
  - Corner inputs are ignored outside this capture.
- Fixed point: all accumulators are signed, Q10.FRAC, 31 bits.
- Per-frame edge steps:
  - Left-edge step = (D−A) × 2185, where 2185 = round(2^20/480).
  - Right-edge step = (C−B) × 2185.
  - Differences are 11-bit signed.
- ROW_SETUP (2 cycles, multiplier may be shared):
  - Column step = ((R−L) × 1638) >>> 20, where 1638 = round(2^20/640).
  - L and R are the current left and right edge accumulators, initialised to A and B.
  - Set P = L, then go to STREAM.
- STREAM:
  - Pulse request_pixel for one cycle, then wait for pixel_flag=1; any latency ≥1 cycle is allowed.
  - Only one request is outstanding at a time. pixel_flag while no request is outstanding is ignored.
  - On the accepted pixel, the next cycle drives pt_wr=1 with:
    - pt_pixel_write = pixel;
    - pt_x = integer part of P.x;
    - pt_y = integer part of P.y (truncation).
  - Then P += column step and x++.
  - After x=639 is accepted, go to ROW_NEXT.
- ROW_NEXT: L += left step; R += right step; x=0; y++. If the finished row was 479, go to IDLE; otherwise go to ROW_SETUP.
- ptflag=0 (latched value): pt_x=x, pt_y=y; the arithmetic results are ignored.
- Every accepted source pixel produces exactly one pt_wr; exactly 307200 per frame.
- frame_flag during a frame is ignored. A new frame starts only from IDLE; frame_flag held high starts the next frame immediately after IDLE is re-entered.
- Reset mid-frame aborts immediately. An in-flight pixel_flag after reset is ignored.

Optional Feature:
- Macro: PT_CLAMP_EN.
- Defined: pt_x is saturated to 0..639 and pt_y to 0..479 before output. Negative accumulators give 0; overflow gives the maximum.
- Undefined: the truncated integer bits are output unmodified (wrap on overflow).

Test Plan:
- Identity quad A=(0,0) B=(639,0) C=(639,479) D=(0,479), ptflag=1, one frame -> every pixel (x,y) written at (x±1,y±1); exactly 307200 pt_wr pulses; pt_pixel_write equals the source pixel.
- Quad A=(0,0) B=(300,100) C=(250,150) D=(50,200) -> first pixel at (0,0); pixel (639,0) at (299..300, 99..100); pixel (0,479) at (49..50, 199..200); pixel (639,479) at (249..250, 149..150).
- ptflag=0 with the same quad -> pt_x/pt_y equal the source raster position exactly; pixel 1000 -> (360,1).
- Handshake: source returns pixel_flag 1, 3 and 7 cycles after request_pixel, and injects a spurious pixel_flag with no request outstanding -> no extra pt_wr; request_pixel never pulses while a request is outstanding.
- reset_n=0 at pixel 5000, then frame_flag -> outputs 0 during reset; new frame restarts at (x,y)=(0,0) with newly latched corners.
- Corners changed mid-frame -> the current frame uses the corners latched at frame start.

Source files
------------

// File: rtl/projective_transform.sv
// Streams a raster source frame and emits each pixel at its bilinear destination inside quad A-B-C-D.
// Optional feature macro PT_CLAMP_EN: saturate pt_x/pt_y to the frame instead of wrapping.
module projective_transform #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int FRAC   = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_flag,
  input  logic [17:0] pixel,
  input  logic        pixel_flag,
  input  logic [9:0]  a_x,
  input  logic [8:0]  a_y,
  input  logic [9:0]  b_x,
  input  logic [8:0]  b_y,
  input  logic [9:0]  c_x,
  input  logic [8:0]  c_y,
  input  logic [9:0]  d_x,
  input  logic [8:0]  d_y,
  input  logic        ptflag,
  output logic [17:0] pt_pixel_write,
  output logic [9:0]  pt_x,
  output logic [8:0]  pt_y,
  output logic        pt_wr,
  output logic        request_pixel
);

  localparam int ACC_W  = 11 + FRAC;
  localparam int SPAN_W = ACC_W + 1;
  localparam int PROD_W = SPAN_W + ACC_W;
  localparam logic signed [ACC_W-1:0] ROW_K = ACC_W'(((1 << FRAC) + HEIGHT / 2) / HEIGHT);
  localparam logic signed [ACC_W-1:0] COL_K = ACC_W'(((1 << FRAC) + WIDTH / 2) / WIDTH);

  typedef enum logic [2:0] {IDLE, SETUP_X, SETUP_Y, REQ, WAIT, ROW_NEXT} state_t;

  state_t state, next;

  logic [9:0] ca_x, cb_x, cc_x, cd_x;
  logic [8:0] ca_y, cb_y, cc_y, cd_y;
  logic       lat_pt;
  logic [9:0] x_cnt;
  logic [8:0] y_cnt;

  logic signed [ACC_W-1:0] l_x, l_y, r_x, r_y, p_x, p_y, step_x, step_y;
  logic signed [ACC_W-1:0] lstep_x, lstep_y, rstep_x, rstep_y;
  logic signed [SPAN_W-1:0] span;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0] col_step;
  logic [9:0] dest_x;
  logic [8:0] dest_y;

  function automatic logic signed [ACC_W-1:0] edge_step(input logic [9:0] p0, input logic [9:0] p1);
    logic signed [10:0] diff;
    diff = $signed({1'b0, p1}) - $signed({1'b0, p0});
    return ACC_W'(diff) * ROW_K;
  endfunction

  always_comb begin
    lstep_x = edge_step(ca_x, cd_x);
    lstep_y = edge_step({1'b0, ca_y}, {1'b0, cd_y});
    rstep_x = edge_step(cb_x, cc_x);
    rstep_y = edge_step({1'b0, cb_y}, {1'b0, cc_y});
  end

  // One multiplier serves both column-step components over the two setup cycles.
  always_comb begin
    if (state == SETUP_Y) span = SPAN_W'(r_y) - SPAN_W'(l_y);
    else                  span = SPAN_W'(r_x) - SPAN_W'(l_x);
    prod     = PROD_W'(span) * PROD_W'(COL_K);
    col_step = ACC_W'(prod >>> FRAC);
  end

  always_comb begin
    dest_x = p_x[FRAC+9:FRAC];
    dest_y = p_y[FRAC+8:FRAC];
`ifdef PT_CLAMP_EN
    if (p_x[ACC_W-1])                           dest_x = '0;
    else if (p_x[ACC_W-1:FRAC] > 11'(WIDTH - 1)) dest_x = 10'(WIDTH - 1);
    if (p_y[ACC_W-1])                            dest_y = '0;
    else if (p_y[ACC_W-1:FRAC] > 11'(HEIGHT - 1)) dest_y = 9'(HEIGHT - 1);
`endif
    if (!lat_pt) begin
      dest_x = x_cnt;
      dest_y = y_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= next;
  end

  always_comb begin
    next          = state;
    request_pixel = 1'b0;
    case (state)
      IDLE:     if (frame_flag) next = SETUP_X;
      SETUP_X:  next = SETUP_Y;
      SETUP_Y:  next = REQ;
      REQ: begin
        request_pixel = 1'b1;
        next          = WAIT;
      end
      WAIT:     if (pixel_flag) next = (x_cnt == 10'(WIDTH - 1)) ? ROW_NEXT : REQ;
      ROW_NEXT: next = (y_cnt == 9'(HEIGHT - 1)) ? IDLE : SETUP_X;
      default:  next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ca_x <= '0; cb_x <= '0; cc_x <= '0; cd_x <= '0;
      ca_y <= '0; cb_y <= '0; cc_y <= '0; cd_y <= '0;
      lat_pt <= 1'b0;
      x_cnt  <= '0;
      y_cnt  <= '0;
      l_x <= '0; l_y <= '0; r_x <= '0; r_y <= '0;
      p_x <= '0; p_y <= '0; step_x <= '0; step_y <= '0;
      pt_pixel_write <= '0;
      pt_x  <= '0;
      pt_y  <= '0;
      pt_wr <= 1'b0;
    end else begin
      pt_wr <= 1'b0;
      case (state)
        IDLE: if (frame_flag) begin
          ca_x <= a_x; cb_x <= b_x; cc_x <= c_x; cd_x <= d_x;
          ca_y <= a_y; cb_y <= b_y; cc_y <= c_y; cd_y <= d_y;
          lat_pt <= ptflag;
          x_cnt  <= '0;
          y_cnt  <= '0;
          l_x <= {1'b0, a_x, {FRAC{1'b0}}};
          l_y <= {2'b0, a_y, {FRAC{1'b0}}};
          r_x <= {1'b0, b_x, {FRAC{1'b0}}};
          r_y <= {2'b0, b_y, {FRAC{1'b0}}};
        end
        SETUP_X: step_x <= col_step;
        SETUP_Y: begin
          step_y <= col_step;
          p_x    <= l_x;
          p_y    <= l_y;
        end
        WAIT: if (pixel_flag) begin
          pt_wr          <= 1'b1;
          pt_pixel_write <= pixel;
          pt_x           <= dest_x;
          pt_y           <= dest_y;
          p_x            <= p_x + step_x;
          p_y            <= p_y + step_y;
          x_cnt          <= x_cnt + 10'd1;
        end
        ROW_NEXT: begin
          l_x   <= l_x + lstep_x;
          l_y   <= l_y + lstep_y;
          r_x   <= r_x + rstep_x;
          r_y   <= r_y + rstep_y;
          x_cnt <= '0;
          y_cnt <= y_cnt + 9'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_projective_transform.sv
// Self-checking bench for projective_transform on a reduced 16x12 frame against an arithmetic model.
module tb_projective_transform;

  localparam int W    = 16;
  localparam int H    = 12;
  localparam int FRAC = 20;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_flag = 1'b0;
  logic [17:0] pixel = '0;
  logic        pixel_flag = 1'b0;
  logic [9:0]  a_x = '0, b_x = '0, c_x = '0, d_x = '0;
  logic [8:0]  a_y = '0, b_y = '0, c_y = '0, d_y = '0;
  logic        ptflag = 1'b0;
  logic [17:0] pt_pixel_write;
  logic [9:0]  pt_x;
  logic [8:0]  pt_y;
  logic        pt_wr;
  logic        request_pixel;

  projective_transform #(.WIDTH(W), .HEIGHT(H), .FRAC(FRAC)) dut (
    .clk(clk), .reset_n(reset_n), .frame_flag(frame_flag),
    .pixel(pixel), .pixel_flag(pixel_flag),
    .a_x(a_x), .a_y(a_y), .b_x(b_x), .b_y(b_y),
    .c_x(c_x), .c_y(c_y), .d_x(d_x), .d_y(d_y),
    .ptflag(ptflag),
    .pt_pixel_write(pt_pixel_write), .pt_x(pt_x), .pt_y(pt_y),
    .pt_wr(pt_wr), .request_pixel(request_pixel)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;
  int m_c[8];   // corners latched by the model: ax ay bx by cx cy dx dy
  bit m_pt;

  always @(posedge clk) if (pt_wr === 1'b1) wr_count++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input int c[8], input bit pt);
    a_x = 10'(c[0]); a_y = 9'(c[1]); b_x = 10'(c[2]); b_y = 9'(c[3]);
    c_x = 10'(c[4]); c_y = 9'(c[5]); d_x = 10'(c[6]); d_y = 9'(c[7]);
    ptflag = pt;
  endtask

  task automatic random_corners(output int c[8]);
    for (int i = 0; i < 8; i++) c[i] = (i % 2 == 0) ? $urandom_range(0, 639) : $urandom_range(0, 479);
  endtask

  // Bilinear interpolation straight from the row/column formulas, no accumulation.
  function automatic int model(input int x, input int y, input bit is_y);
    longint k_row, k_col, a, b, c, d, left, right, step, p, ip;
    int base;
    if (!m_pt) return is_y ? y : x;
    base  = is_y ? 1 : 0;
    a = m_c[base]; b = m_c[2 + base]; c = m_c[4 + base]; d = m_c[6 + base];
    k_row = ((longint'(1) <<< FRAC) + H / 2) / H;
    k_col = ((longint'(1) <<< FRAC) + W / 2) / W;
    left  = (a <<< FRAC) + longint'(y) * ((d - a) * k_row);
    right = (b <<< FRAC) + longint'(y) * ((c - b) * k_row);
    step  = ((right - left) * k_col) >>> FRAC;
    p     = left + longint'(x) * step;
    ip    = p >>> FRAC;
`ifdef PT_CLAMP_EN
    if (ip < 0) ip = 0;
    else if (ip > (is_y ? H - 1 : W - 1)) ip = is_y ? H - 1 : W - 1;
    return int'(ip);
`else
    return int'(ip) & (is_y ? 'h1ff : 'h3ff);
`endif
  endfunction

  task automatic serve_pixel(input int x, input int y, input int lat);
    int n = 0;
    logic extra = 1'b0;
    logic [17:0] pix = 18'($urandom);
    int ex, ey;
    while (request_pixel !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("request(%0d,%0d)", x, y), {63'b0, request_pixel}, 64'd1);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      extra |= request_pixel;
    end
    pixel = pix;
    pixel_flag = 1'b1;
    @(negedge clk);
    pixel_flag = 1'b0;
    ex = model(x, y, 1'b0);
    ey = model(x, y, 1'b1);
    check($sformatf("write(%0d,%0d)", x, y),
          {25'b0, extra, pt_wr, pt_x, pt_y, pt_pixel_write},
          {25'b0, 1'b0, 1'b1, 10'(ex), 9'(ey), pix});
  endtask

  // lat_mode 0: random latency 1..4; 1: cycles through 1, 3, 7. Returns early after pixel stop_at.
  task automatic run_frame(input int lat_mode, input int stop_at, input bit scramble);
    int idx = 0;
    int junk[8];
    int lats[3] = '{1, 3, 7};
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        serve_pixel(x, y, lat_mode == 0 ? $urandom_range(1, 4) : lats[idx % 3]);
        if (idx == stop_at) return;
        if (scramble && idx == 5) begin
          random_corners(junk);
          drive(junk, ~m_pt);
        end
        idx++;
      end
      pixel = 18'h3ffff;   // stray flag with no request outstanding
      pixel_flag = 1'b1;
      @(negedge clk);
      pixel_flag = 1'b0;
    end
  endtask

  task automatic start_frame(input int c[8], input bit pt, input bit hold);
    drive(c, pt);
    m_c  = c;
    m_pt = pt;
    frame_flag = 1'b1;
    @(negedge clk);
    if (!hold) frame_flag = 1'b0;
  endtask

  initial begin
    int c[8];
    int quad[8] = '{0, 0, 300, 100, 250, 150, 50, 200};
    int base;

    repeat (3) @(negedge clk);
    check("reset_outputs", {25'b0, request_pixel, pt_wr, pt_x, pt_y, pt_pixel_write}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Frame 1: identity quad, random latency, corners scrambled mid-frame.
    c = '{0, 0, W - 1, 0, W - 1, H - 1, 0, H - 1};
    base = wr_count;
    start_frame(c, 1'b1, 1'b0);
    run_frame(0, -1, 1'b1);
    check("frame1_wr_count", 64'(wr_count - base), 64'(W * H));

    // Frame 2: skewed quad, latencies 1/3/7, frame_flag held; next frame's corners driven mid-frame.
    base = wr_count;
    start_frame(quad, 1'b1, 1'b1);
    random_corners(c);
    drive(c, 1'b0);
    run_frame(1, -1, 1'b0);
    check("frame2_wr_count", 64'(wr_count - base), 64'(W * H));

    // Frame 3 starts from IDLE because frame_flag stayed high; identity mapping, aborted by reset.
    m_c  = c;
    m_pt = 1'b0;
    @(negedge clk);
    frame_flag = 1'b0;
    base = wr_count - 0;
    run_frame(0, 50, 1'b0);
    reset_n = 1'b0;
    pixel_flag = 1'b1;
    @(negedge clk);
    check("reset_midframe_outputs", {25'b0, request_pixel, pt_wr, pt_x, pt_y, pt_pixel_write}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    pixel_flag = 1'b0;
    @(negedge clk);
    check("after_reset_outputs", {25'b0, request_pixel, pt_wr, pt_x, pt_y, pt_pixel_write}, 64'd0);
    check("frame3_wr_count", 64'(wr_count - base), 64'd51);

    // Frame 4: fresh random corners after reset, must restart at (0,0).
    random_corners(c);
    base = wr_count;
    start_frame(c, 1'b1, 1'b0);
    run_frame(0, -1, 1'b0);
    check("frame4_wr_count", 64'(wr_count - base), 64'(W * H));

    repeat (5) @(negedge clk);
    check("idle_no_request", {63'b0, request_pixel}, 64'd0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
